// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Multi-cycle HI/LO multiply/divide unit with busy handshake.
//             Optional MADD/MADDU/MSUB/MSUBU enabled by macro MDU_MADD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    localparam logic [3:0] c_MUL_CYCLES = 4'd5;
    localparam logic [3:0] c_DIV_CYCLES = 4'd10;

    logic [1:0]  r_state;
    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_sh_hi;
    logic [31:0] r_sh_lo;
    logic        r_sh_wr;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_mthi;
    logic        w_is_mtlo;
    logic        w_signed;
`ifdef MDU_MADD_EN
    logic        w_is_acc;
    logic        w_is_sub;
`endif

    always_comb begin
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        w_is_mthi = 1'b0;
        w_is_mtlo = 1'b0;
        w_signed  = 1'b0;
`ifdef MDU_MADD_EN
        w_is_acc  = 1'b0;
        w_is_sub  = 1'b0;
`endif
        case (op)
            c_OP_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            c_OP_MULTU: begin w_is_mul = 1'b1; end
            c_OP_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
            c_OP_DIVU:  begin w_is_div = 1'b1; end
            c_OP_MTHI:  begin w_is_mthi = 1'b1; end
            c_OP_MTLO:  begin w_is_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
            c_OP_MADD:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_is_acc = 1'b1; end
            c_OP_MADDU: begin w_is_mul = 1'b1; w_is_acc = 1'b1; end
            c_OP_MSUB:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_is_acc = 1'b1; w_is_sub = 1'b1; end
            c_OP_MSUBU: begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic w_accept;
    assign w_accept = start & ~req & (r_state == c_ST_IDLE)
                    & (w_is_mul | w_is_div | w_is_mthi | w_is_mtlo);

    // Sign-extending into 64 bits lets one unsigned multiplier serve both forms.
    logic        w_ext_a;
    logic        w_ext_b;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;
    assign w_ext_a = w_signed & rs_data[31];
    assign w_ext_b = w_signed & rt_data[31];
    assign w_prod  = {{32{w_ext_a}}, rs_data} * {{32{w_ext_b}}, rt_data};

`ifdef MDU_MADD_EN
    assign w_mul_res = !w_is_acc ? w_prod
                     : (w_is_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod));
`else
    assign w_mul_res = w_prod;
`endif

    // Magnitude divide avoids the undefined INT_MIN / -1 case and gives truncation toward zero.
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    assign w_a_neg    = w_signed & rs_data[31];
    assign w_b_neg    = w_signed & rt_data[31];
    assign w_div_zero = (rt_data == 32'd0);
    assign w_a_mag    = w_a_neg ? (32'd0 - rs_data) : rs_data;
    assign w_b_mag    = w_div_zero ? 32'd1 : (w_b_neg ? (32'd0 - rt_data) : rt_data);
    assign w_q_mag    = w_a_mag / w_b_mag;
    assign w_r_mag    = w_a_mag % w_b_mag;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_count <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
            r_sh_wr <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mthi) r_hi <= rs_data;
                        if (w_is_mtlo) r_lo <= rs_data;
                        if (w_is_mul) begin
                            {r_sh_hi, r_sh_lo} <= w_mul_res;
                            r_sh_wr <= 1'b1;
                            r_state <= c_ST_MUL;
                            r_count <= c_MUL_CYCLES;
                        end
                        if (w_is_div) begin
                            r_sh_hi <= w_rem;
                            r_sh_lo <= w_quot;
                            r_sh_wr <= ~w_div_zero;
                            r_state <= c_ST_DIV;
                            r_count <= c_DIV_CYCLES;
                        end
                    end
                end
                c_ST_MUL, c_ST_DIV: begin
                    r_count <= r_count - 4'd1;
                    if (r_count <= 4'd1) begin
                        r_count <= 4'd0;
                        r_state <= c_ST_IDLE;
                        if (r_sh_wr) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_count <= 4'd0;
                end
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Directed vector bench for mult_div_unit (HI/LO, busy timing).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int c, input logic [31:0] h, input logic [31:0] l);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.cycles = c; v.exp_hi = h; v.exp_lo = l;
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, scramble the operand buses, count busy cycles (bounded).
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        step;
        start = 1'b0; op = 4'd0; rs_data = $urandom; rt_data = $urandom;
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            step;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;

        vecs.push_back(mk(4'd1, 32'hFFFFFFFE, 32'h00000003,  5, 32'hFFFFFFFF, 32'hFFFFFFFA));
        vecs.push_back(mk(4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd4, 32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC));
        vecs.push_back(mk(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000));
        vecs.push_back(mk(4'd5, 32'h12345678, 32'h0,         0, 32'h12345678, 32'h80000000));
        vecs.push_back(mk(4'd6, 32'hCAFEBABE, 32'h0,         0, 32'h12345678, 32'hCAFEBABE));
        vecs.push_back(mk(4'd4, 32'h00000005, 32'h00000000, 10, 32'h12345678, 32'hCAFEBABE));
        vecs.push_back(mk(4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd1, 32'h00000007, 32'hFFFFFFFD,  5, 32'hFFFFFFFF, 32'hFFFFFFEB));
        vecs.push_back(mk(4'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 10, 32'hFFFFFFFE, 32'h00000002));
        vecs.push_back(mk(4'd15, 32'h11111111, 32'h2,        0, 32'hFFFFFFFE, 32'h00000002));
        vecs.push_back(mk(4'd0, 32'h11111111, 32'h2,         0, 32'hFFFFFFFE, 32'h00000002));
`ifdef MDU_MADD_EN
        vecs.push_back(mk(4'd5, 32'h00000000, 32'h0,         0, 32'h00000000, 32'h00000002));
        vecs.push_back(mk(4'd6, 32'hFFFFFFFF, 32'h0,         0, 32'h00000000, 32'hFFFFFFFF));
        vecs.push_back(mk(4'd8, 32'h00000001, 32'h1,         5, 32'h00000001, 32'h00000000));
        vecs.push_back(mk(4'd9, 32'h00000001, 32'h1,         5, 32'h00000000, 32'hFFFFFFFF));
`else
        vecs.push_back(mk(4'd7, 32'h00000003, 32'h3,         0, 32'hFFFFFFFE, 32'h00000002));
        vecs.push_back(mk(4'd10, 32'h00000003, 32'h3,        0, 32'hFFFFFFFE, 32'h00000002));
`endif

        // Reset state, observed while reset is still asserted
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        #9 reset = 1'b0;
        step;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // DIVU 100/7 with a MULT start and a req-qualified start injected mid-flight
        start = 1'b1; op = 4'd4; rs_data = 32'd100; rt_data = 32'd7;
        step;
        start = 1'b0; op = 4'd0;
        cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            start = 1'b0; req = 1'b0; op = 4'd0;
            if (cyc == 3) begin
                start = 1'b1; op = 4'd1; rs_data = 32'd2; rt_data = 32'd2;
            end
            if (cyc == 5) begin
                start = 1'b1; req = 1'b1; op = 4'd6; rs_data = 32'h5555;
            end
            step;
        end
        start = 1'b0; req = 1'b0; op = 4'd0;
        check("inflight_busy_cycles", 32'(cyc), 32'd10);
        check("inflight_lo", lo, 32'd14);
        check("inflight_hi", hi, 32'd2);
        step;
        check("inflight_no_restart", 32'(busy), 32'd0);

        // req suppresses acceptance in IDLE, including MTHI
        start = 1'b1; req = 1'b1; op = 4'd5; rs_data = 32'h11111111;
        step;
        check("req_mthi_hi", hi, 32'd2);
        op = 4'd1; rs_data = 32'd3; rt_data = 32'd3;
        step;
        check("req_mult_busy", 32'(busy), 32'd0);
        start = 1'b0; req = 1'b0; op = 4'd0;
        step;

        // Reset mid-operation aborts with no HI/LO update
        start = 1'b1; op = 4'd2; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
        step;
        start = 1'b0; op = 4'd0;
        step;
        step;
        #2 reset = 1'b1;
        #1;
        check("abort_busy_immediate", 32'(busy), 32'd0);
        check("abort_hi_immediate", hi, 32'd0);
        check("abort_lo_immediate", lo, 32'd0);
        step;
        #2 reset = 1'b0;
        step;
        step;
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_hi_after", hi, 32'd0);
        check("abort_lo_after", lo, 32'd0);

        // First operation after reset release
        issue(4'd1, 32'd3, 32'd4, cyc);
        check("post_reset_busy_cycles", 32'(cyc), 32'd5);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req  input  1  exception/interrupt entry this cycle; the E-stage instruction is being cancelled.
REQ-005 start  input  1  E-stage instruction is a valid MDU operation this cycle.
REQ-006 op  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-10 are per REQ-027; all other codes are NONE.
REQ-007 rs_data  input  32  first operand (forwarded E-stage rs value).
REQ-008 rt_data  input  32  second operand (forwarded E-stage rt value).
REQ-009 busy  output  1  an operation is in flight; the hazard unit stalls MDU instructions while busy or start is high.
REQ-010 hi  output  32  current HI register.
REQ-011 lo  output  32  current LO register.

Function
REQ-012 States SHALL be IDLE, MUL, and DIV, with a 4-bit down-counter.
REQ-013 Accepted: start=1, req=0, state IDLE, and op non-NONE; all other combinations SHALL be ignored with no state change.
REQ-014 MULT/MULTU accepted at edge T: latch operands and the 64-bit product into shadow registers, go to MUL with counter=5; busy SHALL be high for cycles T+1..T+5.
REQ-015 DIV/DIVU accepted at edge T: latch the results, go to DIV with counter=10; busy SHALL be high for cycles T+1..T+10.
REQ-016 Each edge in MUL/DIV SHALL decrement the counter. At the edge where the counter goes 1->0, hi/lo SHALL take the shadow results, the state SHALL return to IDLE, and busy SHALL fall in the same cycle that hi/lo show the new values.
REQ-017 MULT product SHALL be signed 32x32->64; MULTU unsigned. hi=product[63:32], lo=product[31:0].
REQ-018 DIV: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend. DIVU: unsigned quotient/remainder.
REQ-019 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-020 Divide by zero (rt_data=0) SHALL still hold busy for 10 cycles and SHALL leave hi/lo unchanged at completion.
REQ-021 MTHI/MTLO accepted at edge T SHALL write rs_data to hi/lo at T, with no busy cycles.
REQ-022 start while busy SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-023 req=1 SHALL suppress acceptance in that cycle, including for MTHI/MTLO. An operation already in flight SHALL complete normally, because its instruction has already committed past E.
REQ-024 Operands SHALL be sampled only at acceptance; later changes on rs_data/rt_data SHALL have no effect.

Reset
REQ-025 While reset is high, the state SHALL be IDLE, counter=0, busy=0, hi=0, lo=0, and shadow results=0, asynchronously and independent of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no hi/lo update; the first accepted start after release SHALL behave per REQ-014/015.

Configuration
REQ-027 Macro MDU_MADD_EN:
- Defined: op 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU are legal. Each SHALL take 5 busy cycles as for MULT. The result {hi,lo} SHALL be {hi,lo} ± the product, with hi/lo sampled at acceptance, signed or unsigned per the op, and wrapping mod 2^64.
- Undefined: op 7-10 SHALL be treated as NONE, and no accumulate logic SHALL exist.

Verification
REQ-028 MULT 0xFFFFFFFE x 0x00000003 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 DIV 0xFFFFFFF9 / 0x00000002 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU of the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-030 MTHI 0x12345678 then DIVU 5/0 -> busy 10 cycles; hi stays 0x12345678 and lo is unchanged.
REQ-031 DIVU 100/7 in flight; at busy cycle 3 apply start=1 with MULT 2x2 and req=1 in a separate cycle -> both ignored; final lo=14, hi=2, total busy 10 cycles.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF, then reset asserted at busy cycle 3 (between clock edges) -> busy, hi, and lo read 0 immediately and stay 0 after the would-be completion edge.
REQ-033 With MDU_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1x1 -> hi=0x00000001, lo=0x00000000 after 5 busy cycles.
